// File: rtl/conv3_layer_sched_pkg.sv
// rtl/conv3_layer_sched_pkg.sv - shared FSM encodings, error codes and defaults for the conv3 layer sequencer
package conv3_layer_sched_pkg;

    localparam int WORD_BYTES_DEF = 4;

    typedef logic [2:0] sched_state_t;

    localparam sched_state_t S_IDLE      = 3'd0;
    localparam sched_state_t S_CHECK     = 3'd1;
    localparam sched_state_t S_ISSUE     = 3'd2;
    localparam sched_state_t S_WAIT_ACK  = 3'd3;
    localparam sched_state_t S_WAIT_DONE = 3'd4;
    localparam sched_state_t S_ADVANCE   = 3'd5;
    localparam sched_state_t S_FINISH    = 3'd6;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_DIMS  = 2'd1;
    localparam logic [1:0] ERR_ABORT = 2'd2;
    localparam logic [1:0] ERR_WDOG  = 2'd3;

endpackage

// File: rtl/conv3_layer_sched_if.sv
// rtl/conv3_layer_sched_if.sv - job handshake and window addresses between the sequencer and the conv engine
interface conv3_layer_sched_if;
    logic        eng_start;
    logic        eng_ready;
    logic [31:0] eng_input_addr;
    logic [31:0] eng_output_addr;

    modport master (output eng_start, output eng_input_addr, output eng_output_addr, input eng_ready);
    modport slave  (input eng_start, input eng_input_addr, input eng_output_addr, output eng_ready);
endinterface

// File: rtl/conv3_addr_walker.sv
// rtl/conv3_addr_walker.sv - row/col walk over the output map with incremental window/result pointers
module conv3_addr_walker #(
    parameter int DIM_W      = 8,
    parameter int WORD_BYTES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [31:0]      in_base,
    input  logic [31:0]      out_base,
    input  logic [DIM_W-1:0] img_w,
    input  logic [DIM_W-1:0] img_h,
    output logic [31:0]      in_ptr,
    output logic [31:0]      out_ptr,
    output logic             last
);
    localparam logic [31:0] STEP = 32'(WORD_BYTES);

    logic [DIM_W-1:0] row, col, row_max, col_max;
    logic [31:0]      in_row_ptr, row_stride;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row        <= '0;
            col        <= '0;
            row_max    <= '0;
            col_max    <= '0;
            in_row_ptr <= '0;
            row_stride <= '0;
            in_ptr     <= '0;
            out_ptr    <= '0;
        end else if (load) begin
            row        <= '0;
            col        <= '0;
            row_max    <= img_h - DIM_W'(3);
            col_max    <= img_w - DIM_W'(3);
            // constant operand: folds to shift/add, evaluated once per layer
            row_stride <= 32'(img_w) * STEP;
            in_row_ptr <= in_base;
            in_ptr     <= in_base;
            out_ptr    <= out_base;
        end else if (step) begin
            out_ptr <= out_ptr + STEP;
            if (col < col_max) begin
                col    <= col + DIM_W'(1);
                in_ptr <= in_ptr + STEP;
            end else begin
                col        <= '0;
                row        <= row + DIM_W'(1);
                in_row_ptr <= in_row_ptr + row_stride;
                in_ptr     <= in_row_ptr + row_stride;
            end
        end
    end

    assign last = (row == row_max) && (col == col_max);

endmodule

// File: rtl/conv3_layer_sched.sv
// rtl/conv3_layer_sched.sv - layer sequencer for the 3x3 conv engine; optional watchdog via CONV3_SCHED_WDOG_EN
module conv3_layer_sched
    import conv3_layer_sched_pkg::*;
#(
    parameter int DIM_W       = 8,
    parameter int WORD_BYTES  = WORD_BYTES_DEF,
    parameter int CNT_W       = 16,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_start,
    input  logic                 cfg_abort,
    input  logic [31:0]          cfg_in_base,
    input  logic [31:0]          cfg_out_base,
    input  logic [DIM_W-1:0]     cfg_img_w,
    input  logic [DIM_W-1:0]     cfg_img_h,
    conv3_layer_sched_if.master  eng,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [CNT_W-1:0]     pix_count
);
    sched_state_t     state, state_nxt;
    logic             start_q, start_acc, abort_pend, abort_hit, dims_bad, wd_fire, walk_last;
    logic [31:0]      in_base_q, out_base_q, in_ptr, out_ptr;
    logic [DIM_W-1:0] w_q, h_q;

    if (WDOG_CYCLES < 1) begin : g_wdog_param_bad
        $error("conv3_layer_sched: WDOG_CYCLES must be at least 1");
    end

    assign start_acc = cfg_start && !start_q && (state == S_IDLE);
    assign dims_bad  = (w_q < DIM_W'(3)) || (h_q < DIM_W'(3));
    assign abort_hit = abort_pend || cfg_abort;

    assign busy                = (state != S_IDLE) && (state != S_FINISH);
    assign done                = (state == S_FINISH);
    assign eng.eng_start       = (state == S_ISSUE);
    assign eng.eng_input_addr  = in_ptr;
    assign eng.eng_output_addr = out_ptr;

    conv3_addr_walker #(.DIM_W(DIM_W), .WORD_BYTES(WORD_BYTES)) u_walker (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == S_CHECK),
        .step     (state == S_ADVANCE),
        .in_base  (in_base_q),
        .out_base (out_base_q),
        .img_w    (w_q),
        .img_h    (h_q),
        .in_ptr   (in_ptr),
        .out_ptr  (out_ptr),
        .last     (walk_last)
    );

`ifdef CONV3_SCHED_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] wd_cnt;
    logic              in_wait;

    assign in_wait = (state == S_WAIT_ACK) || (state == S_WAIT_DONE);
    assign wd_fire = in_wait && (wd_cnt == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || !in_wait || (state_nxt != state)) wd_cnt <= '0;
        else                                            wd_cnt <= wd_cnt + WDOG_W'(1);
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start_acc) state_nxt = S_CHECK;
            S_CHECK:     state_nxt = dims_bad ? S_FINISH : S_ISSUE;
            S_ISSUE:     state_nxt = S_WAIT_ACK;
            S_WAIT_ACK:  if (wd_fire) state_nxt = S_FINISH;
                         else if (!eng.eng_ready) state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (wd_fire) state_nxt = S_FINISH;
                         else if (eng.eng_ready) state_nxt = S_ADVANCE;
            S_ADVANCE:   state_nxt = (walk_last || abort_hit) ? S_FINISH : S_ISSUE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            start_q    <= 1'b0;
            abort_pend <= 1'b0;
            in_base_q  <= '0;
            out_base_q <= '0;
            w_q        <= '0;
            h_q        <= '0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            pix_count  <= '0;
        end else begin
            state   <= state_nxt;
            start_q <= cfg_start;
            if (start_acc) begin
                in_base_q  <= cfg_in_base;
                out_base_q <= cfg_out_base;
                w_q        <= cfg_img_w;
                h_q        <= cfg_img_h;
                abort_pend <= 1'b0;
                err        <= 1'b0;
                err_code   <= ERR_NONE;
                pix_count  <= '0;
            end else begin
                if (busy && cfg_abort) abort_pend <= 1'b1;
                case (state)
                    S_CHECK: if (dims_bad) begin
                        err      <= 1'b1;
                        err_code <= ERR_DIMS;
                    end
                    S_WAIT_ACK, S_WAIT_DONE: if (wd_fire) begin
                        err      <= 1'b1;
                        err_code <= ERR_WDOG;
                    end
                    S_ADVANCE: begin
                        if (pix_count != {CNT_W{1'b1}}) pix_count <= pix_count + CNT_W'(1);
                        // the job that just finished is never cut short; abort lands here
                        if (abort_hit) begin
                            err      <= 1'b1;
                            err_code <= ERR_ABORT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv3_layer_sched.sv
// tb/tb_conv3_layer_sched.sv - scoreboard bench for conv3_layer_sched with a 13-cycle engine model
module tb_conv3_layer_sched;

    typedef struct packed {
        logic [31:0] ia;
        logic [31:0] oa;
    } job_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start, cfg_abort;
    logic [31:0] cfg_in_base, cfg_out_base;
    logic [7:0]  cfg_img_w, cfg_img_h;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [15:0] pix_count;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rise_cyc;
    int   eng_cnt;
    bit   eng_hang = 1'b0;
    job_t exp_q[$];
    int   issue_cyc[$];
    job_t mon_e;

    conv3_layer_sched_if eng_if ();

    conv3_layer_sched #(.DIM_W(8), .WORD_BYTES(4), .CNT_W(16), .WDOG_CYCLES(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_start    (cfg_start),
        .cfg_abort    (cfg_abort),
        .cfg_in_base  (cfg_in_base),
        .cfg_out_base (cfg_out_base),
        .cfg_img_w    (cfg_img_w),
        .cfg_img_h    (cfg_img_h),
        .eng          (eng_if),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_code     (err_code),
        .pix_count    (pix_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // engine: ready drops the cycle after start and returns 13 cycles later
    always @(posedge clk) begin
        if (!rst_n) begin
            eng_if.eng_ready <= 1'b1;
            eng_cnt          <= 0;
        end else if (eng_if.eng_ready && eng_if.eng_start) begin
            eng_if.eng_ready <= 1'b0;
            eng_cnt          <= 13;
        end else if (!eng_if.eng_ready && !eng_hang) begin
            if (eng_cnt <= 1) eng_if.eng_ready <= 1'b1;
            else              eng_cnt <= eng_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && eng_if.eng_start === 1'b1) begin
            issue_cyc.push_back(cyc);
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_job: in_addr=%h out_addr=%h, no job expected",
                         eng_if.eng_input_addr, eng_if.eng_output_addr);
            end else begin
                mon_e = exp_q.pop_front();
                if (eng_if.eng_input_addr !== mon_e.ia || eng_if.eng_output_addr !== mon_e.oa) begin
                    fails++;
                    $display("FAIL job_addr: got in=%h out=%h, expected in=%h out=%h",
                             eng_if.eng_input_addr, eng_if.eng_output_addr, mon_e.ia, mon_e.oa);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic launch(input logic [7:0] w, input logic [7:0] h,
                          input logic [31:0] ib, input logic [31:0] ob, input int njobs);
        job_t e;
        int   idx = 0;
        cfg_img_w    = w;
        cfg_img_h    = h;
        cfg_in_base  = ib;
        cfg_out_base = ob;
        for (int r = 0; r + 2 < int'(h); r++)
            for (int c = 0; c + 2 < int'(w); c++) begin
                if (idx < njobs) begin
                    e.ia = ib + 32'(r * int'(w) * 4 + c * 4);
                    e.oa = ob + 32'(idx * 4);
                    exp_q.push_back(e);
                end
                idx++;
            end
        issue_cyc.delete();
        cfg_start = 1'b1;
        rise_cyc  = cyc;
        tick(1);
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc, output bit ok);
        ok   = 1'b0;
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok   = 1'b1;
                dcyc = cyc;
                break;
            end
        end
    endtask

    task automatic wait_issues(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (issue_cyc.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_dut();
        tests++;
        if ({busy, done, err, err_code, pix_count, eng_if.eng_start} !== '0) begin
            fails++;
            $display("FAIL reset_status: got busy=%b done=%b err=%b code=%0d pix=%0d start=%b, expected all 0",
                     busy, done, err, err_code, pix_count, eng_if.eng_start);
        end
        tests++;
        if (eng_if.eng_input_addr !== 32'h0 || eng_if.eng_output_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_addr: got in=%h out=%h, expected 0", eng_if.eng_input_addr, eng_if.eng_output_addr);
        end
    endtask

    task automatic test_basic();
        int d;
        bit ok;
        launch(8'd4, 8'd4, 32'h100, 32'h800, 99);
        wait_done(200, d, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL basic_done: done not seen, expected within 200 cycles"); end
        tests++;
        if (issue_cyc.size() != 4) begin
            fails++; $display("FAIL basic_jobs: got %0d jobs, expected 4", issue_cyc.size());
        end else begin
            tests++;
            if (issue_cyc[0] != rise_cyc + 2) begin
                fails++; $display("FAIL basic_first_issue: got cycle %0d, expected %0d", issue_cyc[0], rise_cyc + 2);
            end
            for (int i = 1; i < 4; i++) begin
                tests++;
                if (issue_cyc[i] - issue_cyc[i-1] != 16) begin
                    fails++; $display("FAIL basic_period: job %0d gap %0d, expected 16", i, issue_cyc[i] - issue_cyc[i-1]);
                end
            end
            tests++;
            if (d != issue_cyc[3] + 16) begin
                fails++; $display("FAIL basic_done_time: got cycle %0d, expected %0d", d, issue_cyc[3] + 16);
            end
        end
        tests++;
        if (pix_count !== 16'd4 || err !== 1'b0 || err_code !== 2'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_status: got pix=%0d err=%b code=%0d busy=%b, expected 4 0 0 0", pix_count, err, err_code, busy);
        end
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL basic_pending: %0d jobs never issued, expected 0", exp_q.size()); end
        tick(1);
        tests++;
        if (done !== 1'b0 || pix_count !== 16'd4) begin
            fails++; $display("FAIL basic_after: got done=%b pix=%0d, expected 0 and 4", done, pix_count);
        end
    endtask

    task automatic test_bad_dims();
        int d;
        bit ok;
        logic [7:0] dims [2][2] = '{'{8'd2, 8'd5}, '{8'd5, 8'd2}};
        for (int k = 0; k < 2; k++) begin
            tick(1);
            launch(dims[k][0], dims[k][1], 32'h0, 32'h1000, 0);
            wait_done(20, d, ok);
            tests++;
            if (!ok || d != rise_cyc + 2) begin
                fails++; $display("FAIL dims_done_time[%0d]: got cycle %0d, expected %0d", k, d, rise_cyc + 2);
            end
            tests++;
            if (err !== 1'b1 || err_code !== 2'd1 || pix_count !== 16'd0 || issue_cyc.size() != 0) begin
                fails++;
                $display("FAIL dims_status[%0d]: got err=%b code=%0d pix=%0d jobs=%0d, expected 1 1 0 0",
                         k, err, err_code, pix_count, issue_cyc.size());
            end
        end
        tick(5);
        tests++;
        if (err !== 1'b1 || err_code !== 2'd1) begin
            fails++; $display("FAIL dims_sticky: got err=%b code=%0d, expected 1 1", err, err_code);
        end
    endtask

    task automatic test_back_to_back();
        int d;
        bit ok;
        launch(8'd3, 8'd3, 32'hFFFF_FFF8, 32'h10, 99);
        tests++;
        if (busy !== 1'b1 || err !== 1'b0 || err_code !== 2'd0 || pix_count !== 16'd0) begin
            fails++;
            $display("FAIL b2b_accept: got busy=%b err=%b code=%0d pix=%0d, expected 1 0 0 0", busy, err, err_code, pix_count);
        end
        wait_done(100, d, ok);
        tests++;
        if (!ok || pix_count !== 16'd1) begin
            fails++; $display("FAIL b2b_first: got done=%b pix=%0d, expected done and 1", ok, pix_count);
        end
        tick(1);
        launch(8'd4, 8'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 99);
        wait_done(100, d, ok);
        tests++;
        if (!ok || pix_count !== 16'd2 || err !== 1'b0 || issue_cyc.size() != 2 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_wrap: got done=%b pix=%0d err=%b jobs=%0d pending=%0d, expected 1 2 0 2 0",
                     ok, pix_count, err, issue_cyc.size(), exp_q.size());
        end
    endtask

    task automatic test_abort();
        int d;
        bit ok;
        tick(1);
        launch(8'd5, 8'd5, 32'h2000, 32'h3000, 2);
        wait_issues(2, 100, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL abort_job2: job 2 not issued, expected within 100 cycles"); end
        tick(5);
        cfg_abort = 1'b1;
        tick(1);
        cfg_abort = 1'b0;
        wait_done(100, d, ok);
        tests++;
        if (!ok || issue_cyc.size() != 2 || pix_count !== 16'd2) begin
            fails++; $display("FAIL abort_count: got done=%b jobs=%0d pix=%0d, expected 1 2 2", ok, issue_cyc.size(), pix_count);
        end
        tests++;
        if (err !== 1'b1 || err_code !== 2'd2) begin
            fails++; $display("FAIL abort_code: got err=%b code=%0d, expected 1 2", err, err_code);
        end
        exp_q.delete();
    endtask

    task automatic test_ignore_restart();
        int d;
        bit ok;
        tick(1);
        launch(8'd5, 8'd5, 32'h4000, 32'h5000, 99);
        wait_issues(1, 50, ok);
        cfg_start   = 1'b1;
        cfg_img_w   = 8'd3;
        cfg_img_h   = 8'd3;
        cfg_in_base = 32'h0;
        tick(3);
        cfg_start = 1'b0;
        tick(20);
        cfg_start = 1'b1;
        tick(2);
        cfg_start = 1'b0;
        wait_done(300, d, ok);
        tests++;
        if (!ok || pix_count !== 16'd9 || err !== 1'b0 || issue_cyc.size() != 9 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL restart_ignored: got done=%b pix=%0d err=%b jobs=%0d pending=%0d, expected 1 9 0 9 0",
                     ok, pix_count, err, issue_cyc.size(), exp_q.size());
        end
        tick(5);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL restart_not_queued: got busy=%b, expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int d;
        bit ok;
        launch(8'd4, 8'd4, 32'h600, 32'h700, 99);
        wait_issues(1, 50, ok);
        tick(6);
        rst_n = 1'b0;
        tick(1);
        tests++;
        if ({busy, done, err, err_code, pix_count, eng_if.eng_start} !== '0 ||
            eng_if.eng_input_addr !== 32'h0 || eng_if.eng_output_addr !== 32'h0) begin
            fails++;
            $display("FAIL midreset_outputs: got busy=%b done=%b err=%b code=%0d pix=%0d start=%b in=%h out=%h, expected all 0",
                     busy, done, err, err_code, pix_count, eng_if.eng_start, eng_if.eng_input_addr, eng_if.eng_output_addr);
        end
        rst_n = 1'b1;
        exp_q.delete();
        tick(1);
        launch(8'd3, 8'd4, 32'h40, 32'h80, 99);
        wait_done(100, d, ok);
        tests++;
        if (!ok || pix_count !== 16'd2 || err !== 1'b0 || issue_cyc.size() != 2 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL midreset_clean: got done=%b pix=%0d err=%b jobs=%0d pending=%0d, expected 1 2 0 2 0",
                     ok, pix_count, err, issue_cyc.size(), exp_q.size());
        end
    endtask

`ifdef CONV3_SCHED_WDOG_EN
    task automatic test_watchdog();
        int d;
        bit ok;
        tick(1);
        eng_hang = 1'b1;
        launch(8'd3, 8'd3, 32'h0, 32'h0, 99);
        wait_done(200, d, ok);
        tests++;
        if (!ok || issue_cyc.size() != 1 || d != issue_cyc[0] + 2 + 64) begin
            fails++; $display("FAIL wdog_time: got done=%b at cycle %0d, expected 64 cycles after WAIT_DONE entry", ok, d);
        end
        tests++;
        if (err !== 1'b1 || err_code !== 2'd3 || eng_if.eng_start !== 1'b0) begin
            fails++; $display("FAIL wdog_code: got err=%b code=%0d start=%b, expected 1 3 0", err, err_code, eng_if.eng_start);
        end
        eng_hang = 1'b0;
        exp_q.delete();
        reset_dut();
    endtask
`endif

    initial begin
        rst_n        = 1'b0;
        cfg_start    = 1'b0;
        cfg_abort    = 1'b0;
        cfg_in_base  = '0;
        cfg_out_base = '0;
        cfg_img_w    = '0;
        cfg_img_h    = '0;
        test_reset();
        test_basic();
        test_bad_dims();
        test_back_to_back();
        test_abort();
        test_ignore_restart();
        test_reset_mid();
`ifdef CONV3_SCHED_WDOG_EN
        test_watchdog();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
